// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB arbiter that keeps fixed-length bursts and locked sequences intact,
// and tracks which master owns the address and data phases for the bus mux.
module ahb_bus_arbiter #(
  parameter int AHB_MASTER_NUM     = 4,
  parameter int AHB_MASTER_IDX_W   = $clog2(AHB_MASTER_NUM),
  parameter int AHB_DEFAULT_MASTER = 0
) (
  input  logic                        ahb_clk_in,
  input  logic                        ahb_rstn_in,
  input  logic [AHB_MASTER_NUM-1:0]   ahb_busreq_in,
  input  logic [AHB_MASTER_NUM-1:0]   ahb_lock_in,
  input  logic [1:0]                  ahb_trans_in,
  input  logic [2:0]                  ahb_burst_in,
  input  logic                        ahb_ready_in,
  output logic [AHB_MASTER_NUM-1:0]   ahb_grant_out,
  output logic [AHB_MASTER_IDX_W-1:0] ahb_master_out,
  output logic [AHB_MASTER_IDX_W-1:0] ahb_data_master_out,
  output logic                        ahb_mastlock_out
);
  localparam int N = AHB_MASTER_NUM;
  localparam int W = AHB_MASTER_IDX_W;

  localparam logic [1:0] TRANS_IDLE   = 2'd0;
  localparam logic [1:0] TRANS_BUSY   = 2'd1;
  localparam logic [1:0] TRANS_NONSEQ = 2'd2;
  localparam logic [1:0] TRANS_SEQ    = 2'd3;

  localparam logic [W-1:0] DEF_IDX   = W'(AHB_DEFAULT_MASTER);
  localparam logic [N-1:0] DEF_GRANT = {{(N-1){1'b0}}, 1'b1} << AHB_DEFAULT_MASTER;

  typedef enum logic [2:0] {
    ARB_IDLE      = 3'd0,
    ARB_GRANT     = 3'd1,
    ARB_BURST     = 3'd2,
    ARB_LOCK      = 3'd3,
    ARB_LOCK_LAST = 3'd4
  } arb_state_t;

  function automatic logic [N-1:0] idx_to_onehot(input logic [W-1:0] idx);
    logic [N-1:0] r;
    r      = {N{1'b0}};
    r[idx] = 1'b1;
    return r;
  endfunction

  function automatic logic [W-1:0] onehot_to_idx(input logic [N-1:0] oh);
    logic [W-1:0] r;
    r = {W{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (oh[i]) r = W'(i);
      else       r = r;
    end
    return r;
  endfunction

  // Scan from the farthest candidate back to ptr+1 so the nearest requester wins.
  // MSB of the result flags that any requester was found.
  function automatic logic [W:0] rr_pick(input logic [N-1:0] req, input logic [W-1:0] ptr);
    logic [W:0]   r;
    logic [W-1:0] idx;
    r = {1'b0, DEF_IDX};
    for (int i = N; i >= 1; i--) begin
      idx = W'((int'(ptr) + i) % N);
      if (req[idx]) r = {1'b1, idx};
      else          r = r;
    end
    return r;
  endfunction

  // Remaining SEQ beats after the NONSEQ beat, minus the final one.
  function automatic logic [3:0] burst_beats(input logic [2:0] burst);
    logic [3:0] r;
    case (burst)
      3'd2, 3'd3: r = 4'd2;
      3'd4, 3'd5: r = 4'd6;
      3'd6, 3'd7: r = 4'd14;
      default:    r = 4'd0;
    endcase
    return r;
  endfunction

  arb_state_t   state_r, state_nxt_s;
  logic [3:0]   cnt_r, cnt_nxt_s;
  logic [W-1:0] ptr_r, ptr_nxt_s;
  logic [N-1:0] grant_r, grant_nxt_s;
  logic [W-1:0] master_r, data_master_r;
  logic         mastlock_r, mastlock_nxt_s;
  logic         arb_en_s;
  logic [W-1:0] grant_idx_s;
  logic         owner_req_s, owner_lock_s, any_req_s;
  logic [W:0]   pick_s;

  assign grant_idx_s  = onehot_to_idx(grant_r);
  assign owner_req_s  = ahb_busreq_in[grant_idx_s];
  assign owner_lock_s = ahb_lock_in[grant_idx_s];
  assign any_req_s    = |ahb_busreq_in;

  // Next state, beat counter, mastlock and arbitration enable
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    mastlock_nxt_s = mastlock_r;
    arb_en_s       = 1'b0;
    case (state_r)
      ARB_IDLE, ARB_GRANT: begin
        if (owner_lock_s && (ahb_trans_in != TRANS_IDLE)) begin
          // Lock is checked first so a locked burst is tracked as a lock.
          state_nxt_s    = ARB_LOCK;
          cnt_nxt_s      = 4'd0;
          mastlock_nxt_s = 1'b1;
        end else if ((ahb_trans_in == TRANS_NONSEQ) && (ahb_burst_in >= 3'd2)) begin
          state_nxt_s    = ARB_BURST;
          cnt_nxt_s      = burst_beats(ahb_burst_in);
          mastlock_nxt_s = 1'b0;
        end else if (((ahb_trans_in == TRANS_SEQ) || (ahb_trans_in == TRANS_BUSY)) && owner_req_s) begin
          // Undefined-length INCR continuing: owner keeps the bus.
          state_nxt_s    = ARB_GRANT;
          mastlock_nxt_s = 1'b0;
        end else begin
          state_nxt_s    = any_req_s ? ARB_GRANT : ARB_IDLE;
          mastlock_nxt_s = 1'b0;
          arb_en_s       = 1'b1;
        end
      end
      ARB_BURST: begin
        mastlock_nxt_s = 1'b0;
        if (ahb_trans_in == TRANS_SEQ) begin
          if (cnt_r == 4'd0) begin
            if (owner_lock_s) begin
              state_nxt_s    = ARB_LOCK;
              mastlock_nxt_s = 1'b1;
            end else begin
              state_nxt_s = ARB_GRANT;
              arb_en_s    = 1'b1;
            end
          end else begin
            cnt_nxt_s = cnt_r - 4'd1;
          end
        end else if (ahb_trans_in == TRANS_BUSY) begin
          cnt_nxt_s = cnt_r;
        end else begin
          cnt_nxt_s   = 4'd0;
          state_nxt_s = ARB_GRANT;
          arb_en_s    = 1'b1;
        end
      end
      ARB_LOCK: begin
        mastlock_nxt_s = 1'b1;
        if (owner_lock_s) state_nxt_s = ARB_LOCK;
        else              state_nxt_s = ARB_LOCK_LAST;
      end
      ARB_LOCK_LAST: begin
        mastlock_nxt_s = 1'b0;
        state_nxt_s    = ARB_GRANT;
        arb_en_s       = 1'b1;
      end
      default: begin
        state_nxt_s    = ARB_IDLE;
        cnt_nxt_s      = 4'd0;
        mastlock_nxt_s = 1'b0;
        arb_en_s       = 1'b1;
      end
    endcase
  end

  // Round-robin grant selection; pointer moves only when the grant changes
  always_comb begin
    pick_s      = rr_pick(ahb_busreq_in, ptr_r);
    grant_nxt_s = grant_r;
    ptr_nxt_s   = ptr_r;
    if (arb_en_s) begin
      if (pick_s[W]) begin
        grant_nxt_s = idx_to_onehot(pick_s[W-1:0]);
        if (pick_s[W-1:0] != grant_idx_s) ptr_nxt_s = pick_s[W-1:0];
        else                               ptr_nxt_s = ptr_r;
      end else begin
        grant_nxt_s = DEF_GRANT;
        ptr_nxt_s   = ptr_r;
      end
    end else begin
      grant_nxt_s = grant_r;
      ptr_nxt_s   = ptr_r;
    end
  end

  // All state and outputs advance only on HREADY; reset wins immediately
  always_ff @(posedge ahb_clk_in) begin
    if (!ahb_rstn_in) begin
      state_r       <= ARB_IDLE;
      cnt_r         <= 4'd0;
      ptr_r         <= DEF_IDX;
      grant_r       <= DEF_GRANT;
      master_r      <= DEF_IDX;
      data_master_r <= DEF_IDX;
      mastlock_r    <= 1'b0;
    end else if (ahb_ready_in) begin
      state_r       <= state_nxt_s;
      cnt_r         <= cnt_nxt_s;
      ptr_r         <= ptr_nxt_s;
      grant_r       <= grant_nxt_s;
      master_r      <= grant_idx_s;
      data_master_r <= master_r;
      mastlock_r    <= mastlock_nxt_s;
    end
  end

  assign ahb_grant_out       = grant_r;
  assign ahb_master_out      = master_r;
  assign ahb_data_master_out = data_master_r;
  assign ahb_mastlock_out    = mastlock_r;

  ahb_bus_arbiter_chk #(
    .N (N),
    .W (W)
  ) u_chk (
    .clk         (ahb_clk_in),
    .rstn        (ahb_rstn_in),
    .ready       (ahb_ready_in),
    .grant       (grant_r),
    .master      (master_r),
    .data_master (data_master_r),
    .mastlock    (mastlock_r)
  );
endmodule

// Structural invariants: grant stays one-hot out of reset and nothing moves in a wait state.
module ahb_bus_arbiter_chk #(
  parameter int N = 4,
  parameter int W = 2
) (
  input logic         clk,
  input logic         rstn,
  input logic         ready,
  input logic [N-1:0] grant,
  input logic [W-1:0] master,
  input logic [W-1:0] data_master,
  input logic         mastlock
);
  a_grant_onehot: assert property (@(posedge clk) rstn |-> $onehot(grant));

  a_wait_hold: assert property (@(posedge clk) (rstn && !ready) |=>
    ($stable(grant) && $stable(master) && $stable(data_master) && $stable(mastlock)));
endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed bench for ahb_bus_arbiter: a vector table for reset, round-robin and INCR4,
// then hand-written sequences for wait states, lock, early termination and mid-burst reset.
module tb_ahb_bus_arbiter;
  logic       clk;
  logic       rstn;
  logic [3:0] busreq;
  logic [3:0] lock;
  logic [1:0] trans;
  logic [2:0] burst;
  logic       ready;
  logic [3:0] grant;
  logic [1:0] master;
  logic [1:0] data_master;
  logic       mastlock;

  int total = 0;
  int bad   = 0;

  ahb_bus_arbiter #(
    .AHB_MASTER_NUM     (4),
    .AHB_MASTER_IDX_W   (2),
    .AHB_DEFAULT_MASTER (0)
  ) dut (
    .ahb_clk_in          (clk),
    .ahb_rstn_in         (rstn),
    .ahb_busreq_in       (busreq),
    .ahb_lock_in         (lock),
    .ahb_trans_in        (trans),
    .ahb_burst_in        (burst),
    .ahb_ready_in        (ready),
    .ahb_grant_out       (grant),
    .ahb_master_out      (master),
    .ahb_data_master_out (data_master),
    .ahb_mastlock_out    (mastlock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rstn;
    logic [3:0] busreq;
    logic [3:0] lock;
    logic [1:0] trans;
    logic [2:0] burst;
    logic       ready;
    logic [3:0] g;
    logic [1:0] m;
    logic [1:0] d;
    logic       l;
  } vec_t;

  vec_t tbl[12];

  task automatic apply(input logic r, input logic [3:0] rq, input logic [3:0] lk,
                       input logic [1:0] tr, input logic [2:0] bu, input logic rd);
    rstn = r; busreq = rq; lock = lk; trans = tr; burst = bu; ready = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic check_out(input string nm, input logic [3:0] g, input logic [1:0] m,
                           input logic [1:0] d, input logic l);
    chk({nm, ".grant"}, int'(grant), int'(g));
    chk({nm, ".master"}, int'(master), int'(m));
    chk({nm, ".data_master"}, int'(data_master), int'(d));
    chk({nm, ".mastlock"}, int'(mastlock), int'(l));
  endtask

  initial begin
    // rstn busreq lock trans burst ready | grant m d lock
    tbl[0]  = '{1'b0, 4'b1111, 4'b0000, 2'd0, 3'd0, 1'b1, 4'b0001, 2'd0, 2'd0, 1'b0};
    tbl[1]  = '{1'b0, 4'b1111, 4'b0000, 2'd0, 3'd0, 1'b1, 4'b0001, 2'd0, 2'd0, 1'b0};
    tbl[2]  = '{1'b1, 4'b1111, 4'b0000, 2'd2, 3'd0, 1'b1, 4'b0010, 2'd0, 2'd0, 1'b0};
    tbl[3]  = '{1'b1, 4'b1111, 4'b0000, 2'd2, 3'd0, 1'b1, 4'b0100, 2'd1, 2'd0, 1'b0};
    tbl[4]  = '{1'b1, 4'b1111, 4'b0000, 2'd2, 3'd0, 1'b1, 4'b1000, 2'd2, 2'd1, 1'b0};
    tbl[5]  = '{1'b1, 4'b1111, 4'b0000, 2'd2, 3'd0, 1'b1, 4'b0001, 2'd3, 2'd2, 1'b0};
    tbl[6]  = '{1'b1, 4'b1111, 4'b0000, 2'd2, 3'd0, 1'b0, 4'b0001, 2'd3, 2'd2, 1'b0};
    tbl[7]  = '{1'b1, 4'b0110, 4'b0000, 2'd0, 3'd0, 1'b1, 4'b0010, 2'd0, 2'd3, 1'b0};
    tbl[8]  = '{1'b1, 4'b0110, 4'b0000, 2'd2, 3'd3, 1'b1, 4'b0010, 2'd1, 2'd0, 1'b0};
    tbl[9]  = '{1'b1, 4'b0110, 4'b0000, 2'd3, 3'd3, 1'b1, 4'b0010, 2'd1, 2'd1, 1'b0};
    tbl[10] = '{1'b1, 4'b0110, 4'b0000, 2'd3, 3'd3, 1'b1, 4'b0010, 2'd1, 2'd1, 1'b0};
    tbl[11] = '{1'b1, 4'b0110, 4'b0000, 2'd3, 3'd3, 1'b1, 4'b0100, 2'd1, 2'd1, 1'b0};

    rstn = 1'b0; busreq = 4'b0000; lock = 4'b0000;
    trans = 2'd0; burst = 3'd0; ready = 1'b1;

    for (int i = 0; i < 12; i++) begin
      apply(tbl[i].rstn, tbl[i].busreq, tbl[i].lock, tbl[i].trans, tbl[i].burst, tbl[i].ready);
      check_out($sformatf("vec%0d", i), tbl[i].g, tbl[i].m, tbl[i].d, tbl[i].l);
    end

    // INCR8 by master 2 with three wait states right after the NONSEQ beat
    apply(1'b1, 4'b1100, 4'b0000, 2'd2, 3'd5, 1'b1);
    check_out("incr8_nonseq", 4'b0100, 2'd2, 2'd1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      apply(1'b1, 4'b1100, 4'b0000, 2'd3, 3'd5, 1'b0);
      check_out($sformatf("incr8_wait%0d", k), 4'b0100, 2'd2, 2'd1, 1'b0);
    end
    for (int k = 1; k <= 6; k++) begin
      apply(1'b1, 4'b1100, 4'b0000, 2'd3, 3'd5, 1'b1);
      check_out($sformatf("incr8_seq%0d", k), 4'b0100, 2'd2, 2'd2, 1'b0);
    end
    apply(1'b1, 4'b1100, 4'b0000, 2'd3, 3'd5, 1'b1);
    check_out("incr8_last", 4'b1000, 2'd2, 2'd2, 1'b0);

    // Master 3 locks for three transfers while master 0 requests
    apply(1'b1, 4'b1001, 4'b1000, 2'd2, 3'd0, 1'b1);
    check_out("lock1", 4'b1000, 2'd3, 2'd2, 1'b1);
    apply(1'b1, 4'b1001, 4'b1000, 2'd2, 3'd0, 1'b1);
    check_out("lock2", 4'b1000, 2'd3, 2'd3, 1'b1);
    apply(1'b1, 4'b1001, 4'b1000, 2'd2, 3'd0, 1'b1);
    check_out("lock3", 4'b1000, 2'd3, 2'd3, 1'b1);
    apply(1'b1, 4'b1001, 4'b0000, 2'd2, 3'd0, 1'b1);
    check_out("lock_tail", 4'b1000, 2'd3, 2'd3, 1'b1);
    apply(1'b1, 4'b1001, 4'b0000, 2'd2, 3'd0, 1'b1);
    check_out("lock_release", 4'b0001, 2'd3, 2'd3, 1'b0);

    // INCR16 by master 0 ended by IDLE after two beats
    apply(1'b1, 4'b0011, 4'b0000, 2'd2, 3'd7, 1'b1);
    check_out("early_nonseq", 4'b0001, 2'd0, 2'd3, 1'b0);
    apply(1'b1, 4'b0011, 4'b0000, 2'd3, 3'd7, 1'b1);
    check_out("early_seq", 4'b0001, 2'd0, 2'd0, 1'b0);
    apply(1'b1, 4'b0011, 4'b0000, 2'd0, 3'd7, 1'b1);
    check_out("early_idle", 4'b0010, 2'd0, 2'd0, 1'b0);

    // INCR16 by master 1 with reset landing on beat 5
    apply(1'b1, 4'b0011, 4'b0000, 2'd2, 3'd7, 1'b1);
    check_out("rstb_nonseq", 4'b0010, 2'd1, 2'd0, 1'b0);
    for (int k = 2; k <= 4; k++) begin
      apply(1'b1, 4'b0011, 4'b0000, 2'd3, 3'd7, 1'b1);
      check_out($sformatf("rstb_beat%0d", k), 4'b0010, 2'd1, 2'd1, 1'b0);
    end
    apply(1'b0, 4'b0011, 4'b0000, 2'd3, 3'd7, 1'b1);
    check_out("rstb_reset", 4'b0001, 2'd0, 2'd0, 1'b0);
    apply(1'b1, 4'b0011, 4'b0000, 2'd0, 3'd0, 1'b1);
    check_out("rstb_rearb", 4'b0010, 2'd0, 2'd0, 1'b0);

    // No requesters, sole requester keeps grant, INCR hold then NONSEQ re-arbitration
    apply(1'b1, 4'b0000, 4'b0000, 2'd0, 3'd0, 1'b1);
    check_out("noreq_default", 4'b0001, 2'd1, 2'd0, 1'b0);
    apply(1'b1, 4'b0100, 4'b0000, 2'd0, 3'd0, 1'b1);
    check_out("solo_grant", 4'b0100, 2'd0, 2'd1, 1'b0);
    apply(1'b1, 4'b0100, 4'b0000, 2'd0, 3'd0, 1'b1);
    check_out("solo_keep", 4'b0100, 2'd2, 2'd0, 1'b0);
    apply(1'b1, 4'b0110, 4'b0000, 2'd3, 3'd1, 1'b1);
    check_out("incr_hold", 4'b0100, 2'd2, 2'd2, 1'b0);
    apply(1'b1, 4'b0110, 4'b0000, 2'd2, 3'd1, 1'b1);
    check_out("incr_rearb", 4'b0010, 2'd2, 2'd2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
